// File: rtl/elite_spi_master.sv
// SPI mode-0 master, MSB first, 8-bit, valid/ready byte input, CSEL held across multi-byte frames.
// Optional build macro SPIM_LOOPBACK_EN adds Loopback_En (capture from MOSI, slave left deselected).
module elite_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic       MClk,
  input  logic       SPIM_Rst_Flag,
  input  logic [7:0] Tx_Byte,
  input  logic       Tx_Last,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  output logic       Busy,
  output logic       SPIM_SCLK,
  output logic       SPIM_MOSI,
  input  logic       SPIM_MISO,
`ifdef SPIM_LOOPBACK_EN
  input  logic       Loopback_En,
`endif
  output logic       SPIM_CSEL
);

  localparam int unsigned M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned M2   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned MAXP = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_NEXT, S_HOLD, S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          last_q;
  logic          done_q;
  logic          lb_q;
  logic          lb_in;
  logic          cap_bit;

`ifdef SPIM_LOOPBACK_EN
  assign lb_in = Loopback_En;
`else
  assign lb_in = 1'b0;
`endif

  // In loopback the bit being presented on MOSI is captured at the falling edge
  assign cap_bit = lb_q ? SPIM_MOSI : SPIM_MISO;

  always_ff @(posedge MClk) begin
    if (SPIM_Rst_Flag) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      lb_q      <= 1'b0;
      SPIM_SCLK <= 1'b0;
      SPIM_CSEL <= 1'b1;
      SPIM_MOSI <= 1'b0;
      Tx_Ready  <= 1'b1;
      Rx_Valid  <= 1'b0;
      Rx_Byte   <= '0;
      Busy      <= 1'b0;
    end else begin
      Rx_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Tx_Valid && Tx_Ready) begin
            lb_q      <= lb_in;
            SPIM_CSEL <= lb_in;
            SPIM_MOSI <= Tx_Byte[7];
            tx_sh     <= {Tx_Byte[6:0], 1'b0};
            last_q    <= Tx_Last;
            done_q    <= 1'b0;
            bit_cnt   <= '0;
            Tx_Ready  <= 1'b0;
            Busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_END) begin
            cnt       <= '0;
            SPIM_SCLK <= 1'b1;
            state     <= S_SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (SPIM_SCLK) begin
              SPIM_SCLK <= 1'b0;
              rx_sh     <= {rx_sh[6:0], cap_bit};
              SPIM_MOSI <= tx_sh[7];
              tx_sh     <= {tx_sh[6:0], 1'b0};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                done_q <= 1'b1;
            end else if (!done_q) begin
              SPIM_SCLK <= 1'b1;
            end else begin
              // Low phase after the 8th fall has completed: byte finished
              done_q   <= 1'b0;
              Rx_Byte  <= rx_sh;
              Rx_Valid <= 1'b1;
              if (last_q) begin
                state <= S_HOLD;
              end else begin
                state    <= S_NEXT;
                Tx_Ready <= 1'b1;
              end
            end
          end
        end
        S_NEXT: begin
          if (Tx_Valid) begin
            SPIM_MOSI <= Tx_Byte[7];
            tx_sh     <= {Tx_Byte[6:0], 1'b0};
            last_q    <= Tx_Last;
            Tx_Ready  <= 1'b0;
            // Pre-load the low-phase count so SCLK rises one cycle after MOSI settles
            cnt       <= DIV_END;
            state     <= S_SHIFT;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt       <= '0;
            SPIM_CSEL <= 1'b1;
            SPIM_MOSI <= 1'b0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt      <= '0;
            Tx_Ready <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elite_spi_master.sv
// Directed bench for elite_spi_master: table of single-byte transfers plus frame, stall, reset,
// back-to-back and (with SPIM_LOOPBACK_EN) loopback sequences against a mode-0 slave model.
module tb_elite_spi_master;

  logic       MClk = 1'b0;
  logic       SPIM_Rst_Flag = 1'b1;
  logic [7:0] Tx_Byte = 8'h00;
  logic       Tx_Last = 1'b0;
  logic       Tx_Valid = 1'b0;
  logic       Tx_Ready;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic       Busy;
  logic       SPIM_SCLK;
  logic       SPIM_MOSI;
  logic       SPIM_MISO = 1'b0;
  logic       SPIM_CSEL;
`ifdef SPIM_LOOPBACK_EN
  logic       Loopback_En = 1'b0;
`endif

  elite_spi_master #(.CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(4)) dut (
    .MClk          (MClk),
    .SPIM_Rst_Flag (SPIM_Rst_Flag),
    .Tx_Byte       (Tx_Byte),
    .Tx_Last       (Tx_Last),
    .Tx_Valid      (Tx_Valid),
    .Tx_Ready      (Tx_Ready),
    .Rx_Byte       (Rx_Byte),
    .Rx_Valid      (Rx_Valid),
    .Busy          (Busy),
    .SPIM_SCLK     (SPIM_SCLK),
    .SPIM_MOSI     (SPIM_MOSI),
    .SPIM_MISO     (SPIM_MISO),
`ifdef SPIM_LOOPBACK_EN
    .Loopback_En   (Loopback_En),
`endif
    .SPIM_CSEL     (SPIM_CSEL)
  );

  always #5 MClk = ~MClk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Mode-0 slave: presents MSB at CSEL fall, next bit after each SCLK fall, samples MOSI on rise
  logic       slv_echo  = 1'b0;
  logic [7:0] slv_const = 8'h00;
  logic [7:0] slv_tx    = 8'h00;
  logic [7:0] slv_rx    = 8'h00;
  int unsigned slv_cnt  = 0;

  always @(negedge SPIM_CSEL) begin
    slv_tx    = slv_echo ? 8'h00 : slv_const;
    SPIM_MISO = slv_tx[7];
    slv_tx    = {slv_tx[6:0], 1'b0};
    slv_cnt   = 0;
  end

  always @(posedge SPIM_SCLK) begin
    slv_rx  = {slv_rx[6:0], SPIM_MOSI};
    slv_cnt = slv_cnt + 1;
  end

  always @(negedge SPIM_SCLK) begin
    if (slv_cnt == 8) begin
      slv_tx  = slv_echo ? slv_rx : slv_const;
      slv_cnt = 0;
    end
    SPIM_MISO = slv_tx[7];
    slv_tx    = {slv_tx[6:0], 1'b0};
  end

  // Monotonic monitors; tests take deltas
  int unsigned rise_cnt   = 0;
  int unsigned rxv_cnt    = 0;
  int unsigned csel_low   = 0;
  int unsigned csel_falls = 0;
  logic [31:0] mosi_hist  = '0;
  logic [7:0]  rx_q[$];

  always @(posedge SPIM_SCLK) begin
    rise_cnt  = rise_cnt + 1;
    mosi_hist = {mosi_hist[30:0], SPIM_MOSI};
  end

  always @(negedge MClk) begin
    if (Rx_Valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_q.push_back(Rx_Byte);
    end
    if (!SPIM_CSEL) csel_low = csel_low + 1;
  end

  always @(negedge SPIM_CSEL) csel_falls = csel_falls + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned t = 0;
    Tx_Byte  = b;
    Tx_Last  = last;
    Tx_Valid = 1'b1;
    while (!Tx_Ready && t < 5000) begin
      @(negedge MClk);
      t++;
    end
    if (!Tx_Ready) timeout_fail("send_byte");
    @(negedge MClk);
    Tx_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned t = 0;
    while (Busy && t < 5000) begin
      @(negedge MClk);
      t++;
    end
    if (Busy) timeout_fail("wait_idle");
  endtask

  task automatic wait_ready();
    int unsigned t = 0;
    while (!Tx_Ready && t < 5000) begin
      @(negedge MClk);
      t++;
    end
    if (!Tx_Ready) timeout_fail("wait_ready");
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t        vecs[4];
  int unsigned r0, v0, c0, f0, q0, viol, hi, acc, t;
  logic        seen;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{tx: 8'hA5, miso: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'h00, miso: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
    vecs[2] = '{tx: 8'hFF, miso: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h80, miso: 8'h01, exp_rx: 8'h01, exp_mosi: 8'h80};

    repeat (3) @(negedge MClk);
    check("rst_sclk",   {31'd0, SPIM_SCLK}, 32'd0);
    check("rst_csel",   {31'd0, SPIM_CSEL}, 32'd1);
    check("rst_mosi",   {31'd0, SPIM_MOSI}, 32'd0);
    check("rst_ready",  {31'd0, Tx_Ready},  32'd1);
    check("rst_rxv",    {31'd0, Rx_Valid},  32'd0);
    check("rst_rxbyte", {24'd0, Rx_Byte},   32'h00);
    check("rst_busy",   {31'd0, Busy},      32'd0);
    SPIM_Rst_Flag = 1'b0;
    repeat (2) @(negedge MClk);

    // Single-byte frames
    for (int i = 0; i < 4; i++) begin
      slv_echo  = 1'b0;
      slv_const = vecs[i].miso;
      r0 = rise_cnt; v0 = rxv_cnt; c0 = csel_low; q0 = rx_q.size();
      send_byte(vecs[i].tx, 1'b1);
      wait_idle();
      check($sformatf("v%0d_rises", i),     rise_cnt - r0, 32'd8);
      check($sformatf("v%0d_rxv_count", i), rxv_cnt - v0, 32'd1);
      check($sformatf("v%0d_rx_byte", i),   {24'd0, Rx_Byte}, {24'd0, vecs[i].exp_rx});
      check($sformatf("v%0d_mosi", i),      {24'd0, mosi_hist[7:0]}, {24'd0, vecs[i].exp_mosi});
      check($sformatf("v%0d_csel_low", i),  csel_low - c0, 32'd72);
      repeat (3) @(negedge MClk);
    end

    // Three-byte frame into echo slave
    slv_echo = 1'b1;
    r0 = rise_cnt; f0 = csel_falls; q0 = rx_q.size();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    wait_idle();
    check("frame_rises", rise_cnt - r0, 32'd24);
    check("frame_csel_falls", csel_falls - f0, 32'd1);
    check("frame_mosi", {8'd0, mosi_hist[23:0]}, 32'h00010203);
    check("frame_rx_count", rx_q.size() - q0, 32'd3);
    if (rx_q.size() >= q0 + 3) begin
      check("frame_rx0", {24'd0, rx_q[q0]},     32'h00);
      check("frame_rx1", {24'd0, rx_q[q0 + 1]}, 32'h01);
      check("frame_rx2", {24'd0, rx_q[q0 + 2]}, 32'h02);
    end
    repeat (3) @(negedge MClk);

    // Stall 20 cycles between bytes of a frame
    r0 = rise_cnt; f0 = csel_falls; q0 = rx_q.size(); viol = 0;
    send_byte(8'h11, 1'b0);
    wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (SPIM_CSEL || SPIM_SCLK || !Tx_Ready) viol++;
      @(negedge MClk);
    end
    send_byte(8'h22, 1'b1);
    wait_idle();
    check("stall_violations", viol, 32'd0);
    check("stall_rises", rise_cnt - r0, 32'd16);
    check("stall_csel_falls", csel_falls - f0, 32'd1);
    check("stall_rx_count", rx_q.size() - q0, 32'd2);
    if (rx_q.size() >= q0 + 2) begin
      check("stall_rx0", {24'd0, rx_q[q0]},     32'h00);
      check("stall_rx1", {24'd0, rx_q[q0 + 1]}, 32'h11);
    end
    repeat (3) @(negedge MClk);

    // Reset after the 3rd SCLK rise
    slv_echo = 1'b0; slv_const = 8'h99;
    r0 = rise_cnt; v0 = rxv_cnt; t = 0;
    send_byte(8'hFF, 1'b1);
    while (rise_cnt - r0 < 3 && t < 2000) begin
      @(negedge MClk);
      t++;
    end
    check("rst_mid_rises", rise_cnt - r0, 32'd3);
    SPIM_Rst_Flag = 1'b1;
    @(negedge MClk);
    SPIM_Rst_Flag = 1'b0;
    check("rst_mid_csel", {31'd0, SPIM_CSEL}, 32'd1);
    check("rst_mid_sclk", {31'd0, SPIM_SCLK}, 32'd0);
    check("rst_mid_mosi", {31'd0, SPIM_MOSI}, 32'd0);
    check("rst_mid_busy", {31'd0, Busy},      32'd0);
    repeat (100) @(negedge MClk);
    check("rst_mid_no_rxv", rxv_cnt - v0, 32'd0);
    slv_const = 8'hC7;
    r0 = rise_cnt;
    send_byte(8'h5A, 1'b1);
    wait_idle();
    check("post_rst_rx",    {24'd0, Rx_Byte}, 32'hC7);
    check("post_rst_mosi",  {24'd0, mosi_hist[7:0]}, 32'h5A);
    check("post_rst_rises", rise_cnt - r0, 32'd8);
    repeat (3) @(negedge MClk);

    // Tx_Valid held high across two Last=1 bytes
    slv_const = 8'h5A;
    r0 = rise_cnt; f0 = csel_falls; v0 = rxv_cnt;
    viol = 0; hi = 0; acc = 0; t = 0; seen = 1'b0;
    Tx_Byte = 8'h81; Tx_Last = 1'b1; Tx_Valid = 1'b1;
    while (acc < 2 && t < 3000) begin
      if (Busy && Tx_Ready) viol++;
      if (!SPIM_CSEL) seen = 1'b1;
      else if (seen) hi++;
      if (Tx_Ready && !Busy) begin
        acc++;
        @(negedge MClk);
        t++;
        Tx_Byte = 8'h42;
        if (acc == 2) Tx_Valid = 1'b0;
      end else begin
        @(negedge MClk);
        t++;
      end
    end
    wait_idle();
    check("b2b_accepts", acc, 32'd2);
    check("b2b_ready_while_busy", viol, 32'd0);
    check("b2b_gap_ge4", {31'd0, (hi >= 4)}, 32'd1);
    check("b2b_csel_falls", csel_falls - f0, 32'd2);
    check("b2b_rises", rise_cnt - r0, 32'd16);
    check("b2b_mosi", {16'd0, mosi_hist[15:0]}, 32'h8142);
    check("b2b_rxv", rxv_cnt - v0, 32'd2);
    repeat (3) @(negedge MClk);

`ifdef SPIM_LOOPBACK_EN
    Loopback_En = 1'b1;
    slv_const = 8'h00;
    r0 = rise_cnt; f0 = csel_falls; c0 = csel_low;
    send_byte(8'hC3, 1'b1);
    wait_idle();
    Loopback_En = 1'b0;
    check("lb_rx", {24'd0, Rx_Byte}, 32'hC3);
    check("lb_csel_falls", csel_falls - f0, 32'd0);
    check("lb_csel_low", csel_low - c0, 32'd0);
    check("lb_rises", rise_cnt - r0, 32'd8);
    repeat (3) @(negedge MClk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
